// File: rtl/player_bullet_pool.sv
// Player bullet slot pool: spawns bullets on fire requests, moves them up once
// per frame, and retires them when they leave the top of the screen or are hit.
module player_bullet_pool #(
    parameter int MAX_PLAYER_BULLET = 15,
    parameter int BULLET_SPEED      = 1,
    parameter int FIRE_COOLDOWN     = 8
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_FrameTick,
    input  logic                           i_Fire,
    input  logic [18:0]                    i_PlayerPosition,
    input  logic [MAX_PLAYER_BULLET-1:0]   i_HitMask,
    output logic [MAX_PLAYER_BULLET-1:0]   o_BulletState,
    output logic [MAX_PLAYER_BULLET*19-1:0] o_BulletPosition,
    output logic                           o_FireAccepted,
    output logic                           o_FireDropped,
    output logic                           o_PoolFull
);

    localparam int N  = MAX_PLAYER_BULLET;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam logic [8:0] SPEED = 9'(BULLET_SPEED);

    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

    state_t        state;
    logic [N-1:0]  active;
    logic [N-1:0]  active_next;
    logic [N-1:0]  hit;
    logic [18:0]   pos      [N];
    logic [18:0]   pos_next [N];
    logic          pending;
    logic [CW-1:0] cooldown;
    logic [IW-1:0] free_idx;
    logic          free_found;
    logic          spawn_ok;
    logic [9:0]    player_x;
    logic [8:0]    player_y;

    assign player_x = i_PlayerPosition[18:9];
    assign player_y = i_PlayerPosition[8:0];
    assign hit      = active & i_HitMask;

    // Lowest-index free slot; a slot being hit this cycle is still occupied.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign spawn_ok = pending && (cooldown == '0) && free_found && (player_y != 9'd0);

    always_comb begin
        active_next = active & ~hit;
        for (int i = 0; i < N; i++) begin
            pos_next[i] = pos[i];
        end
        if (state == UPDATE) begin
            for (int i = 0; i < N; i++) begin
                if (active_next[i]) begin
                    if (pos[i][8:0] < SPEED) begin
                        active_next[i] = 1'b0;
                    end else begin
                        pos_next[i][8:0] = pos[i][8:0] - SPEED;
                    end
                end
            end
        end
        if (state == SPAWN && spawn_ok) begin
            active_next[free_idx] = 1'b1;
            pos_next[free_idx]    = {player_x, player_y - 9'd1};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state          <= IDLE;
            active         <= '0;
            pending        <= 1'b0;
            cooldown       <= '0;
            o_FireAccepted <= 1'b0;
            o_FireDropped  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                pos[i] <= '0;
            end
        end else begin
            active         <= active_next;
            o_FireAccepted <= 1'b0;
            o_FireDropped  <= 1'b0;
            pending        <= pending | i_Fire;
            for (int i = 0; i < N; i++) begin
                pos[i] <= pos_next[i];
            end
            case (state)
                IDLE: begin
                    if (i_FrameTick) state <= UPDATE;
                end
                UPDATE: begin
                    state <= SPAWN;
                    if (cooldown != '0) cooldown <= cooldown - CW'(1);
                end
                SPAWN: begin
                    state   <= IDLE;
                    // A fire arriving during SPAWN waits for the next frame.
                    pending <= i_Fire;
                    if (pending) begin
                        if (spawn_ok) begin
                            cooldown       <= CW'(FIRE_COOLDOWN);
                            o_FireAccepted <= 1'b1;
                        end else begin
                            o_FireDropped  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_BulletState = active;
        for (int i = 0; i < N; i++) begin
            o_BulletPosition[19*i +: 19] = pos[i];
        end
    end

    assign o_PoolFull = &active;

endmodule

// File: tb/tb_player_bullet_pool.sv
// Bench for player_bullet_pool: directed scenarios plus random traffic, all
// checked every cycle against a frame-level behavioural model.
module tb_player_bullet_pool;

    localparam int N     = 15;
    localparam int SPEED = 1;
    localparam int COOL  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic            fire;
    logic [18:0]     ppos;
    logic [N-1:0]    hitm;
    logic [N-1:0]    bstate;
    logic [N*19-1:0] bpos;
    logic            acc;
    logic            drop;
    logic            full;

    player_bullet_pool #(
        .MAX_PLAYER_BULLET(N),
        .BULLET_SPEED(SPEED),
        .FIRE_COOLDOWN(COOL)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_FrameTick(tick),
        .i_Fire(fire),
        .i_PlayerPosition(ppos),
        .i_HitMask(hitm),
        .o_BulletState(bstate),
        .o_BulletPosition(bpos),
        .o_FireAccepted(acc),
        .o_FireDropped(drop),
        .o_PoolFull(full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = waiting for a tick, 1 = move cycle, 2 = spawn cycle.
    int phase;
    bit m_act [N];
    int m_x   [N];
    int m_y   [N];
    bit m_pend;
    int m_cd;
    bit m_acc;
    bit m_drop;

    task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] xy(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    task automatic model_reset();
        phase  = 0;
        m_pend = 0;
        m_cd   = 0;
        m_acc  = 0;
        m_drop = 0;
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit f,
                              input logic [18:0] pp, input logic [N-1:0] h);
        bit hn [N];
        int px, py, slot;
        if (r) begin
            model_reset();
            return;
        end
        px     = int'(pp[18:9]);
        py     = int'(pp[8:0]);
        m_acc  = 0;
        m_drop = 0;
        for (int i = 0; i < N; i++) hn[i] = m_act[i] && h[i];
        if (phase == 1) begin
            for (int i = 0; i < N; i++) begin
                if (m_act[i] && !hn[i]) begin
                    if (m_y[i] < SPEED) m_act[i] = 0;
                    else m_y[i] = m_y[i] - SPEED;
                end
            end
            if (m_cd > 0) m_cd--;
        end
        if (phase == 2 && m_pend) begin
            slot = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
            if (m_cd == 0 && slot >= 0 && py != 0) begin
                m_act[slot] = 1;
                m_x[slot]   = px;
                m_y[slot]   = py - 1;
                m_cd        = COOL;
                m_acc       = 1;
            end else begin
                m_drop = 1;
            end
        end
        for (int i = 0; i < N; i++) if (hn[i]) m_act[i] = 0;
        m_pend = ((phase == 2) ? 1'b0 : m_pend) | f;
        phase  = (phase == 0) ? (t ? 1 : 0) : ((phase == 1) ? 2 : 0);
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0]    es;
        logic [N*19-1:0] ep;
        for (int i = 0; i < N; i++) begin
            es[i]           = m_act[i];
            ep[19*i +: 19]  = {10'(m_x[i]), 9'(m_y[i])};
        end
        check_val({tag, ".state"}, 320'(bstate), 320'(es));
        check_val({tag, ".pos"},   320'(bpos),   320'(ep));
        check_val({tag, ".acc"},   320'(acc),    320'(m_acc));
        check_val({tag, ".drop"},  320'(drop),   320'(m_drop));
        check_val({tag, ".full"},  320'(full),   320'(&es));
    endtask

    task automatic cycle(input bit r, input bit t, input bit f, input logic [18:0] pp,
                         input logic [N-1:0] h, input string tag);
        @(negedge clk);
        rst  = r;
        tick = t;
        fire = f;
        ppos = pp;
        hitm = h;
        @(posedge clk);
        model_step(r, t, f, pp, h);
        #1 compare_all(tag);
    endtask

    // Fire rides on the tick cycle; the hit mask is applied on the move cycle.
    task automatic frame(input bit f, input logic [18:0] pp, input logic [N-1:0] h, input string tag);
        cycle(0, 1, f, pp, '0, tag);
        cycle(0, 0, 0, pp, h, tag);
        cycle(0, 0, 0, pp, '0, tag);
    endtask

    initial begin
        logic [N-1:0] rh;
        rst  = 1'b1;
        tick = 1'b0;
        fire = 1'b0;
        ppos = '0;
        hitm = '0;
        model_reset();

        // First shot and one frame of movement
        cycle(1, 0, 0, xy(100, 200), '0, "rst");
        cycle(1, 0, 0, xy(100, 200), '0, "rst");
        check_val("rst.state0", 320'(bstate), 320'(0));
        check_val("rst.pos0",   320'(bpos),   320'(0));
        cycle(0, 0, 1, xy(100, 200), '0, "t1");
        frame(0, xy(100, 200), '0, "t1");
        check_val("t1.accept", 320'(acc), 320'(1));
        check_val("t1.slot0",  320'(bpos[18:0]), 320'(xy(100, 199)));
        check_val("t1.bits",   320'(bstate), 320'(15'h0001));
        cycle(0, 0, 0, xy(100, 200), '0, "t1");
        check_val("t1.onepulse", 320'(acc), 320'(0));
        frame(0, xy(100, 200), '0, "t1");
        check_val("t1.moved", 320'(bpos[18:0]), 320'(xy(100, 198)));

        // Cooldown: drop on the next frame, accept eight frames after the shot
        frame(1, xy(100, 200), '0, "cool");
        check_val("cool.drop", 320'(drop), 320'(1));
        for (int k = 2; k < COOL; k++) frame(0, xy(100, 200), '0, "cool");
        frame(1, xy(100, 200), '0, "cool");
        check_val("cool.accept", 320'(acc), 320'(1));
        check_val("cool.bits",   320'(bstate), 320'(15'h0003));
        check_val("cool.slot1",  320'(bpos[37:19]), 320'(xy(100, 199)));

        // Bullet retires at y=0 and the same-frame shot reuses slot 0
        cycle(1, 0, 0, xy(50, 9), '0, "y0");
        cycle(0, 0, 1, xy(50, 9), '0, "y0");
        frame(0, xy(50, 9), '0, "y0");
        for (int k = 0; k < COOL; k++) frame(0, xy(50, 9), '0, "y0");
        check_val("y0.atzero", 320'(bpos[18:0]), 320'(xy(50, 0)));
        frame(1, xy(60, 300), '0, "y0");
        check_val("y0.accept", 320'(acc), 320'(1));
        check_val("y0.bits",   320'(bstate), 320'(15'h0001));
        check_val("y0.slot0",  320'(bpos[18:0]), 320'(xy(60, 299)));

        // Fill the pool, then fire into it
        cycle(1, 0, 0, xy(7, 500), '0, "fill");
        for (int k = 0; k < (N - 1) * COOL + 1; k++) frame(1, xy(7, 500), '0, "fill");
        for (int k = 0; k < COOL; k++) frame(0, xy(7, 500), '0, "fill");
        check_val("fill.full", 320'(full), 320'(1));
        frame(1, xy(7, 500), '0, "fill");
        check_val("fill.drop", 320'(drop),   320'(1));
        check_val("fill.bits", 320'(bstate), 320'(15'h7FFF));

        // Hit on slot 3 during the move cycle
        frame(0, xy(7, 500), 15'h0008, "hit");
        check_val("hit.bits", 320'(bstate), 320'(15'h7FF7));

        // Reset during the spawn cycle loses the pending shot
        cycle(1, 0, 0, xy(100, 200), '0, "rspawn");
        cycle(0, 0, 1, xy(100, 200), '0, "rspawn");
        cycle(0, 1, 0, xy(100, 200), '0, "rspawn");
        cycle(0, 0, 0, xy(100, 200), '0, "rspawn");
        cycle(1, 0, 0, xy(100, 200), '0, "rspawn");
        check_val("rspawn.acc",  320'(acc),    320'(0));
        check_val("rspawn.bits", 320'(bstate), 320'(0));
        frame(0, xy(100, 200), '0, "rspawn");
        check_val("rspawn.lost", 320'(acc),    320'(0));
        check_val("rspawn.none", 320'(bstate), 320'(0));

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rh = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom & $urandom) : '0;
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  xy($urandom_range(0, 1023),
                     ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 511)),
                  rh, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_bullet_pool.md
Name: player_bullet_pool

Overview:
- Producer side of the bullet datapath: owns the player bullet slots and drives the per-slot state and position buses that the bullet mover consumes.
- Allocates a free slot on a fire request and advances every active bullet once per frame.
- Retires bullets that leave the top of the screen or are reported hit.
- Sits between the player input/position logic and the bullet mover / renderer.

Parameters:
- MAX_PLAYER_BULLET, 15: number of bullet slots (N).
- BULLET_SPEED, 1: pixels per frame that each bullet moves upward; must be at least 1.
- FIRE_COOLDOWN, 8: frames after an accepted shot during which fire requests are dropped.

Ports:
- i_Clk  input  1  system clock.
- i_Rst  input  1  reset; synchronous, active-high.
- i_FrameTick  input  1  one-cycle pulse per video frame.
- i_Fire  input  1  fire request, sampled every cycle.
- i_PlayerPosition  input  19  player position; [18:9] = x, [8:0] = y.
- i_HitMask  input  N  per-slot hit report from collision logic.
- o_BulletState  output  N  1 = slot active.
- o_BulletPosition  output  N*19  slot i occupies bits [19*i+18 : 19*i]; same x/y packing as i_PlayerPosition.
- o_FireAccepted  output  1  one-cycle pulse when a bullet is spawned.
- o_FireDropped  output  1  one-cycle pulse when a pending request is discarded.
- o_PoolFull  output  1  all N slots active (combinational AND of o_BulletState).

Behaviour:
- Reset (i_Rst high at a clock edge, any state, including mid-UPDATE/SPAWN):
  - state to IDLE.
  - o_BulletState = 0, all o_BulletPosition = 0.
  - fire-pending flag = 0, cooldown counter = 0.
  - o_FireAccepted = 0, o_FireDropped = 0.
- Fire-pending flag:
  - Set by i_Fire in any cycle.
  - Cleared only in SPAWN.
  - Multiple i_Fire pulses within one frame collapse into one request.
- Hit handling, every cycle in every state:
  - Any slot with o_BulletState[i] & i_HitMask[i] clears its state bit on the next edge.
  - Hit takes priority over movement and over spawn into that slot in the same cycle.
  - Its position register holds its old value.
  - i_HitMask bits for inactive slots are ignored.
- FSM states: IDLE, UPDATE, SPAWN.
  - IDLE to UPDATE when i_FrameTick = 1.
  - UPDATE to SPAWN unconditionally; SPAWN to IDLE unconditionally.
  - i_FrameTick pulses while in UPDATE or SPAWN are ignored; ticks must be at least 3 cycles apart.
- UPDATE (one cycle), for each active, not-hit slot:
  - If y < BULLET_SPEED: the slot retires (state cleared, no wrap).
  - Otherwise: y := y - BULLET_SPEED, x unchanged (9-bit unsigned subtract).
  - Cooldown counter decrements by 1, saturating at 0.
- SPAWN (one cycle), only if the pending flag is set:
  - Accept when all hold: cooldown == 0, at least one free slot exists (evaluated after this frame's UPDATE retirements), and player y != 0.
  - On accept:
    - Choose the lowest-index free slot.
    - Load its position {player x, player y - 1} using i_PlayerPosition sampled in this cycle.
    - Set its state bit.
    - Load cooldown = FIRE_COOLDOWN.
    - Pulse o_FireAccepted.
  - Otherwise: pulse o_FireDropped; cooldown unchanged.
  - In both cases the pending flag clears.
  - An i_Fire arriving in the SPAWN cycle itself is kept as pending for the next frame.
- Latency:
  - Movement is visible 1 cycle after the tick edge.
  - A new bullet is visible 2 cycles after the tick edge.
  - Hits take effect 1 cycle after the hit.
- Inactive slots hold their last position; consumers gate with o_BulletState.

Test Plan:
- Reset, then i_Fire, then tick, with player at (100,200):
  - Slot 0 becomes active at (100,199) two cycles after the tick.
  - o_FireAccepted pulses once.
  - Next tick moves it to (100,198).
- Fire on two consecutive frames with FIRE_COOLDOWN = 8:
  - The second request produces o_FireDropped.
  - A request on the 9th frame after the first shot is accepted into slot 1.
- Bullet at y=0 on a tick:
  - The slot retires in UPDATE.
  - A same-frame fire with cooldown 0 reuses that slot (the lowest free index).
- Fill all 15 slots (o_PoolFull = 1, no slot at y < 1), then fire:
  - o_FireDropped pulses; state stays 15'h7FFF.
- i_HitMask[3] = 1 asserted on the same cycle as UPDATE:
  - Slot 3 clears and its position does not move.
  - Other slots move by 1.
- Assert i_Rst during SPAWN with a request pending:
  - All outputs zero next cycle; no o_FireAccepted.
  - The pending request is lost.
